// File: rtl/aes_block_packer.sv
// aes_block_packer: packs four 32-bit stream words into a 128-bit block for
// AESEncrypt, issues a one-cycle start pulse and waits for the engine to finish.
// Optional CBC chaining is enabled by defining AES_PACK_CBC_EN.
module aes_block_packer #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TO_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [127:0]     aes_data_in,
    output logic             aes_ready,
    input  logic             aes_valid,
    input  logic [127:0]     aes_data_out,
    input  logic [127:0]     iv,
    input  logic             iv_load,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] blocks_issued
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        word_cnt;
    logic [3:0][31:0]  pack;
    logic [TO_W-1:0]   to_cnt;
    logic              accept_c;
    logic [127:0]      block_c;

    // A word moves only on a completed handshake.
    assign accept_c = s_valid && s_ready;

`ifdef AES_PACK_CBC_EN
    logic [127:0] chain;

    // Block presented to the engine: three buffered words plus the incoming last word, chained.
    assign block_c = {pack[3:1], s_data} ^ chain;

    // Chain register: iv only at a block boundary, engine output on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else if (state == FILL && word_cnt == 2'd0 && iv_load) begin
            chain <= iv;
        end else if (state == WAIT && aes_valid) begin
            chain <= aes_data_out;
        end
    end
`else
    logic unused_cbc;

    // Block presented to the engine: three buffered words plus the incoming last word.
    assign block_c    = {pack[3:1], s_data};
    assign unused_cbc = ^{iv, iv_load, aes_data_out};
`endif

    // Packing FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= FILL;
            word_cnt      <= 2'd0;
            pack          <= '0;
            to_cnt        <= '0;
            s_ready       <= 1'b0;
            aes_ready     <= 1'b0;
            aes_data_in   <= '0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
            blocks_issued <= '0;
        end else begin
            aes_ready <= 1'b0;
            case (state)
                FILL: begin
                    s_ready <= 1'b1;
                    busy    <= (word_cnt != 2'd0);
                    if (accept_c) begin
                        pack[2'd3 - word_cnt] <= s_data;
                        word_cnt              <= word_cnt + 2'd1;
                        busy                  <= 1'b1;
                        if (word_cnt == 2'd3) begin
                            state         <= ISSUE;
                            s_ready       <= 1'b0;
                            aes_ready     <= 1'b1;
                            aes_data_in   <= block_c;
                            blocks_issued <= blocks_issued + CNT_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    state   <= WAIT;
                    to_cnt  <= '0;
                    s_ready <= 1'b0;
                    busy    <= 1'b1;
                end
                WAIT: begin
                    if (aes_valid) begin
                        state   <= FILL;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                    end else if (TIMEOUT != 0 && to_cnt == TO_LAST) begin
                        state       <= FILL;
                        s_ready     <= 1'b1;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        to_cnt  <= to_cnt + TO_W'(1);
                        s_ready <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state   <= FILL;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_packer.sv
// Scoreboard bench for aes_block_packer: stimulus pushes expected blocks, a
// monitor pops them on each aes_ready pulse, an engine model answers requests.
`timescale 1ns/1ps
module tb_aes_block_packer;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned TO_W    = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      s_data;
    logic             s_valid;
    logic             s_ready;
    logic [127:0]     aes_data_in;
    logic             aes_ready;
    logic             aes_valid;
    logic [127:0]     aes_data_out;
    logic [127:0]     iv;
    logic             iv_load;
    logic             busy;
    logic             timeout_err;
    logic [CNT_W-1:0] blocks_issued;

    int errors = 0;
    int checks = 0;

    logic [CNT_W+127:0] exp_q[$];
    logic [CNT_W-1:0]   exp_cnt;

    int           eng_delay  = 1;
    logic         eng_busy   = 1'b0;
    logic         eng_valid  = 1'b0;
    logic         spur_valid = 1'b0;
    logic [127:0] eng_out    = '0;

    assign aes_valid    = eng_valid | spur_valid;
    assign aes_data_out = spur_valid ? {4{32'hA5A5_5A5A}} : eng_out;

    always #5 clk = ~clk;

    aes_block_packer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .aes_data_in  (aes_data_in),
        .aes_ready    (aes_ready),
        .aes_valid    (aes_valid),
        .aes_data_out (aes_data_out),
        .iv           (iv),
        .iv_load      (iv_load),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .blocks_issued(blocks_issued)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_s_ready",       128'(s_ready),       128'(0));
        check("rst_aes_ready",     128'(aes_ready),     128'(0));
        check("rst_aes_data_in",   aes_data_in,         128'(0));
        check("rst_busy",          128'(busy),          128'(0));
        check("rst_timeout_err",   128'(timeout_err),   128'(0));
        check("rst_blocks_issued", 128'(blocks_issued), 128'(0));
    endtask

    // Offer one word after 'gap' idle cycles; returns at the negedge after acceptance.
    task automatic send_word(input logic [31:0] w, input int gap);
        int   n;
        logic got;
        for (int i = 0; i < gap; i++) @(negedge clk);
        s_valid = 1'b1;
        s_data  = w;
        n       = 0;
        do begin
            got = s_ready;
            @(negedge clk);
            n++;
        end while (!got && n < 500);
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_word: s_ready stayed %b for word %h, required 1", s_ready, w);
        end
        s_valid = 1'b0;
        s_data  = 32'hDEAD_BEEF;
    endtask

    task automatic send_block(input logic [127:0] words, input logic [127:0] exp_blk, input int gap);
        exp_cnt = exp_cnt + CNT_W'(1);
        exp_q.push_back({exp_blk, exp_cnt});
        for (int k = 0; k < 4; k++) send_word(words[127-32*k -: 32], gap);
    endtask

    // Wait until the scoreboard is drained, the engine is idle and the packer accepts words.
    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((eng_busy || exp_q.size() != 0 || !s_ready) && n < 500);
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: s_ready=%b eng_busy=%b pending=%0d, required idle", s_ready, eng_busy, exp_q.size());
        end
    endtask

    // Monitor: every aes_ready pulse must match the next expected block and count.
    initial begin
        logic               prev;
        logic [CNT_W+127:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (aes_ready) begin
                check("aes_ready_one_cycle", 128'(prev), 128'(0));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got aes_ready with data %h, required no pulse", aes_data_in);
                end else begin
                    e = exp_q.pop_front();
                    check("block_data",    aes_data_in,         e[CNT_W+127:CNT_W]);
                    check("blocks_issued", 128'(blocks_issued), 128'(e[CNT_W-1:0]));
                end
            end
            prev = aes_ready;
        end
    end

    // Engine model: answers each request after eng_delay WAIT cycles, or never when 0.
    initial begin
        int           d;
        logic [127:0] held;
        forever begin
            @(negedge clk);
            if (aes_ready && !reset) begin
                d        = eng_delay;
                held     = aes_data_in;
                eng_busy = 1'b1;
                if (d == 0) begin
                    for (int i = 1; i <= int'(TIMEOUT) + 1; i++) begin
                        @(negedge clk);
                        if (i == int'(TIMEOUT)) begin
                            check("no_timeout_yet",  128'(timeout_err), 128'(0));
                            check("wait_s_ready_lo", 128'(s_ready),     128'(0));
                        end
                        if (i == int'(TIMEOUT) + 1) begin
                            check("timeout_err_set",      128'(timeout_err), 128'(1));
                            check("s_ready_after_tmo",    128'(s_ready),     128'(1));
                        end
                    end
                end else begin
                    for (int i = 1; i <= d; i++) begin
                        @(negedge clk);
                        check("wait_s_ready",    128'(s_ready), 128'(0));
                        check("wait_data_stable", aes_data_in,  held);
                        if (i == d) eng_valid = 1'b1;
                    end
                    @(negedge clk);
                    eng_valid = 1'b0;
                    check("s_ready_after_done", 128'(s_ready), 128'(1));
                end
                eng_busy = 1'b0;
            end
        end
    end

    // Directed stimulus.
    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        iv      = '0;
        iv_load = 1'b0;
        exp_cnt = '0;
        #1;
        check_reset_vals();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("s_ready_post_reset", 128'(s_ready), 128'(1));

        // Basic block, fastest engine.
        eng_delay = 1;
        send_block(128'h00112233_44556677_8899AABB_CCDDEEFF, 128'h00112233_44556677_8899AABB_CCDDEEFF, 0);
        check("issue_latency", 128'(aes_ready), 128'(1));
        check("busy_in_issue", 128'(busy),      128'(1));
        wait_idle();
        check("busy_idle", 128'(busy), 128'(0));

        // Gapped input, slow engine, two back-to-back blocks.
        eng_delay = 10;
        send_block(128'h01020304_05060708_090A0B0C_0D0E0F10, 128'h01020304_05060708_090A0B0C_0D0E0F10, 2);
        send_block(128'hF0E0D0C0_B0A09080_70605040_30201000, 128'hF0E0D0C0_B0A09080_70605040_30201000, 2);
        wait_idle();

        // Spurious aes_valid in FILL, both at a boundary and mid-block.
        eng_delay  = 1;
        spur_valid = 1'b1;
        @(negedge clk);
        spur_valid = 1'b0;
        check("spur_busy", 128'(busy),    128'(0));
        check("spur_rdy",  128'(s_ready), 128'(1));
        exp_cnt = exp_cnt + CNT_W'(1);
        exp_q.push_back({128'hCAFEBABE_12345678_9ABCDEF0_0F1E2D3C, exp_cnt});
        send_word(32'hCAFEBABE, 0);
        send_word(32'h12345678, 0);
        spur_valid = 1'b1;
        @(negedge clk);
        spur_valid = 1'b0;
        check("spur_mid_busy", 128'(busy), 128'(1));
        send_word(32'h9ABCDEF0, 0);
        send_word(32'h0F1E2D3C, 0);
        wait_idle();

        // Engine answers on the exact timeout cycle: completion wins.
        eng_delay = int'(TIMEOUT);
        send_block(128'h11111111_22222222_33333333_44444444, 128'h11111111_22222222_33333333_44444444, 0);
        wait_idle();
        check("collision_no_err", 128'(timeout_err), 128'(0));

        // Reset after two words discards the partial block.
        send_word(32'hAAAA0000, 0);
        send_word(32'hBBBB1111, 0);
        reset = 1'b1;
        #1;
        check_reset_vals();
        @(negedge clk);
        reset   = 1'b0;
        exp_cnt = '0;
        eng_delay = 1;
        send_block(128'h55555555_66666666_77777777_88888888, 128'h55555555_66666666_77777777_88888888, 0);
        wait_idle();

        // Engine never answers: timeout, then normal operation resumes.
        eng_delay = 0;
        send_block(128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000, 128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000, 0);
        wait_idle();
        eng_delay = 1;
        send_block(128'h13579BDF_2468ACE0_0ECA8642_FDB97531, 128'h13579BDF_2468ACE0_0ECA8642_FDB97531, 0);
        wait_idle();
        check("timeout_sticky", 128'(timeout_err), 128'(1));

`ifdef AES_PACK_CBC_EN
        // Chaining: iv then engine output are XORed into successive zero blocks.
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        exp_cnt = '0;
        @(negedge clk);
        iv      = {128{1'b1}};
        iv_load = 1'b1;
        @(negedge clk);
        iv_load = 1'b0;
        iv      = '0;
        eng_out = 128'h0123456789ABCDEF0123456789ABCDEF;
        send_block(128'h0, {128{1'b1}}, 0);
        wait_idle();
        eng_out = '0;
        send_block(128'h0, 128'h0123456789ABCDEF0123456789ABCDEF, 0);
        wait_idle();
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
